fetch_unit: RTL and testbench

- Front end of the 5-stage core: owns the PC, issues requests to instruction memory and delivers instructions into the IF/ID pipeline register.
- Consumes the stall controls (stall_pc, stall_ifid) and the flush/redirect from EX.
- Variable-latency, in-order instruction memory. Responses arriving while ID is stalled are held in a small buffer so no fetch is lost.

---
 rtl/fetch_unit_pkg.sv | 10 +
 rtl/fetch_buffer.sv | 56 +++++
 rtl/fetch_unit.sv | 144 ++++++++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch front end.
// Defaults here are picked up by fetch_unit's parameters.
package fetch_unit_pkg;

    localparam int          DEFAULT_XLEN         = 32;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int          INSTR_W              = 32;
    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, instr} entries that holds fetch responses while ID is stalled.
// The head is read combinationally so it can load IF/ID in the same cycle it is popped.
module fetch_buffer #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;
    assign empty     = (count_reg == '0);

endmodule

// File: rtl/fetch_unit.sv
// Core front end: owns the PC, issues credit-limited fetches to an in-order memory
// and fills the IF/ID register, buffering responses that arrive while ID is stalled.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
    parameter int              BUF_DEPTH    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_pc,
    input  logic               stall_ifid,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    output logic               ifid_valid,
    output logic [XLEN-1:0]    ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr
);

    localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;
    localparam int ENTRY_W = XLEN + INSTR_W;

    logic [XLEN-1:0]    pc_reg, pc_next;
    logic [XLEN-1:0]    resp_pc_reg, resp_pc_next;
    logic [CNT_W-1:0]   outstanding_reg, outstanding_next;
    logic [CNT_W-1:0]   discard_reg, discard_next;
    logic               ifid_valid_reg, ifid_valid_next;
    logic [XLEN-1:0]    ifid_pc_reg, ifid_pc_next;
    logic [INSTR_W-1:0] ifid_instr_reg, ifid_instr_next;

    logic [ENTRY_W-1:0] buf_head;
    logic [CNT_W-1:0]   buf_count;
    logic               buf_empty;
    logic               buf_push, buf_pop;
    logic [CNT_W:0]     inflight;
    logic               accept, resp_drop, resp_live, load, bypass;

    // Credit covers both in-flight requests and buffered entries, so every
    // response is guaranteed a slot; only registered state feeds req_valid.
    assign inflight       = {1'b0, outstanding_reg} + {1'b0, buf_count};
    assign imem_req_valid = !rst && !stall_pc && !redirect_valid
                            && (inflight < (CNT_W + 1)'(BUF_DEPTH));
    assign imem_req_addr  = pc_reg;
    assign accept         = imem_req_valid && imem_req_ready;

    assign resp_drop = imem_resp_valid && (discard_reg != '0);
    assign resp_live = imem_resp_valid && (discard_reg == '0) && !redirect_valid;
    assign load      = !stall_ifid && !redirect_valid;
    assign buf_pop   = load && !buf_empty;
    assign bypass    = load && buf_empty && resp_live;
    assign buf_push  = resp_live && !bypass;

    // Fetches are sequential between redirects, so the PC of each live response
    // is tracked by a counter instead of a per-request tag queue.
    always_comb begin
        pc_next          = pc_reg;
        resp_pc_next     = resp_pc_reg;
        outstanding_next = outstanding_reg + CNT_W'(accept) - CNT_W'(imem_resp_valid);
        discard_next     = discard_reg;
        ifid_valid_next  = ifid_valid_reg;
        ifid_pc_next     = ifid_pc_reg;
        ifid_instr_next  = ifid_instr_reg;

        if (redirect_valid) begin
            pc_next         = redirect_pc;
            resp_pc_next    = redirect_pc;
            discard_next    = outstanding_reg - CNT_W'(imem_resp_valid);
            ifid_valid_next = 1'b0;
            ifid_pc_next    = '0;
            ifid_instr_next = NOP_INSTR;
        end else begin
            if (accept) begin
                pc_next = pc_reg + XLEN'(4);
            end
            if (resp_drop) begin
                discard_next = discard_reg - CNT_W'(1);
            end
            if (resp_live) begin
                resp_pc_next = resp_pc_reg + XLEN'(4);
            end
            if (load) begin
                if (buf_pop) begin
                    ifid_valid_next = 1'b1;
                    ifid_pc_next    = buf_head[ENTRY_W-1:INSTR_W];
                    ifid_instr_next = buf_head[INSTR_W-1:0];
                end else if (bypass) begin
                    ifid_valid_next = 1'b1;
                    ifid_pc_next    = resp_pc_reg;
                    ifid_instr_next = imem_resp_data;
                end else begin
                    ifid_valid_next = 1'b0;
                    ifid_pc_next    = '0;
                    ifid_instr_next = NOP_INSTR;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg          <= RESET_VECTOR;
            resp_pc_reg     <= RESET_VECTOR;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            ifid_valid_reg  <= 1'b0;
            ifid_pc_reg     <= '0;
            ifid_instr_reg  <= NOP_INSTR;
        end else begin
            pc_reg          <= pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            ifid_valid_reg  <= ifid_valid_next;
            ifid_pc_reg     <= ifid_pc_next;
            ifid_instr_reg  <= ifid_instr_next;
        end
    end

    fetch_buffer #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data ({resp_pc_reg, imem_resp_data}),
        .pop       (buf_pop),
        .flush     (redirect_valid),
        .head_data (buf_head),
        .count     (buf_count),
        .empty     (buf_empty)
    );

    assign ifid_valid = ifid_valid_reg;
    assign ifid_pc    = ifid_pc_reg;
    assign ifid_instr = ifid_instr_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a variable-latency in-order memory model;
// expected PCs and request addresses are hand-derived per scenario.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_pc = 1'b0;
    logic        stall_ifid = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_instr;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lat = 1;
    mem_req_t    mem_q[$];
    logic [31:0] aq[$];
    logic [31:0] dq[$];

    fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .stall_pc        (stall_pc),
        .stall_ifid      (stall_ifid),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .ifid_valid      (ifid_valid),
        .ifid_pc         (ifid_pc),
        .ifid_instr      (ifid_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return {16'hC0DE, addr[15:0]};
    endfunction

    function automatic logic [31:0] dq_at(input int i);
        return (i < dq.size()) ? dq[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] aq_at(input int i);
        return (i < aq.size()) ? aq[i] : 32'hFFFF_FFFF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // One clock: memory drives its response at negedge, handshakes are sampled
    // just before the edge, and IF/ID is checked just after it.
    task automatic tick();
        logic        acc, rsp, ld;
        logic [31:0] acc_addr;
        mem_req_t    e;
        @(negedge clk);
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = instr_of(mem_q[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        rsp      = imem_resp_valid;
        ld       = !stall_ifid && !redirect_valid;
        @(posedge clk);
        cyc++;
        if (rsp) void'(mem_q.pop_front());
        if (acc) begin
            e.addr = acc_addr;
            e.due  = cyc + lat - 1;
            mem_q.push_back(e);
            aq.push_back(acc_addr);
        end
        #1;
        if (ld && ifid_valid) dq.push_back(ifid_pc);
        if (ifid_valid) check_eq("ifid_instr", ifid_instr, instr_of(ifid_pc));
        else            check_eq("bubble_instr", ifid_instr, NOP);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall_pc = 1'b0;
        stall_ifid = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data = '0;
        mem_q.delete();
        aq.delete();
        dq.delete();
        @(posedge clk);
        #1;
        check_eq("rst_req_valid", 32'(imem_req_valid), 0);
        check_eq("rst_req_addr", imem_req_addr, 32'h0);
        check_eq("rst_ifid_valid", 32'(ifid_valid), 0);
        check_eq("rst_ifid_pc", ifid_pc, 32'h0);
        check_eq("rst_ifid_instr", ifid_instr, NOP);
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] dropped[$];
        int          n_acc;
        int          stale;
        logic        hit;

        // Straight-line fetch with a 1-cycle memory.
        do_reset();
        lat = 1;
        tick();
        check_eq("t1_first_addr", aq_at(0), 32'h0);
        check_eq("t1_not_yet_valid", 32'(ifid_valid), 0);
        tick();
        check_eq("t1_valid0", 32'(ifid_valid), 1);
        check_eq("t1_pc0", ifid_pc, 32'h0);
        tick();
        check_eq("t1_valid1", 32'(ifid_valid), 1);
        check_eq("t1_pc1", ifid_pc, 32'h4);
        tick();
        check_eq("t1_valid2", 32'(ifid_valid), 1);
        check_eq("t1_pc2", ifid_pc, 32'h8);
        check_eq("t1_addr3", aq_at(3), 32'hC);

        // Both stalls for 3 cycles while IF/ID holds 0x8.
        n_acc = aq.size();
        stall_pc = 1'b1;
        stall_ifid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t2_hold_valid", 32'(ifid_valid), 1);
            check_eq("t2_hold_pc", ifid_pc, 32'h8);
            check_eq("t2_buf_bound", 32'(dut.buf_count <= 2), 1);
        end
        check_eq("t2_no_accepts", 32'(aq.size()), 32'(n_acc));
        stall_pc = 1'b0;
        stall_ifid = 1'b0;
        tick();
        check_eq("t2_after_pc", ifid_pc, 32'hC);
        check_eq("t2_after_valid", 32'(ifid_valid), 1);
        tick();
        check_eq("t2_next_pc", ifid_pc, 32'h10);
        check_eq("t2_next_valid", 32'(ifid_valid), 1);

        // Redirect with two requests in flight on a 3-cycle memory.
        do_reset();
        lat = 3;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            if (mem_q.size() == 2 && aq.size() >= 4) hit = 1'b1;
        end
        check_eq("t3_two_outstanding", 32'(hit), 1);
        dropped.delete();
        foreach (mem_q[i]) dropped.push_back(mem_q[i].addr);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        tick();
        check_eq("t3_redir_bubble", 32'(ifid_valid), 0);
        check_eq("t3_redir_addr", imem_req_addr, 32'h100);
        redirect_valid = 1'b0;
        n_acc = aq.size();
        dq.delete();
        repeat (15) tick();
        check_eq("t3_first_req", aq_at(n_acc), 32'h100);
        check_eq("t3_first_deliv", dq_at(0), 32'h100);
        check_eq("t3_second_deliv", dq_at(1), 32'h104);
        stale = 0;
        foreach (dq[i]) foreach (dropped[j]) if (dq[i] == dropped[j]) stale++;
        check_eq("t3_no_stale", 32'(stale), 0);

        // Back-pressure: request at 0x20 held for 4 cycles.
        do_reset();
        lat = 1;
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            tick();
            if (imem_req_addr == 32'h20) hit = 1'b1;
        end
        check_eq("t4_reach_0x20", 32'(hit), 1);
        imem_req_ready = 1'b0;
        n_acc = aq.size();
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("t4_valid_held", 32'(imem_req_valid), 1);
            check_eq("t4_addr_held", imem_req_addr, 32'h20);
        end
        check_eq("t4_no_accepts", 32'(aq.size()), 32'(n_acc));
        imem_req_ready = 1'b1;
        tick();
        check_eq("t4_accepted", aq_at(n_acc), 32'h20);
        check_eq("t4_pc_advanced", imem_req_addr, 32'h24);

        // Redirect in the same cycle as both stalls: redirect wins.
        stall_pc = 1'b1;
        stall_ifid = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        tick();
        check_eq("t5_bubble_valid", 32'(ifid_valid), 0);
        check_eq("t5_bubble_instr", ifid_instr, NOP);
        check_eq("t5_req_addr", imem_req_addr, 32'h200);
        stall_pc = 1'b0;
        stall_ifid = 1'b0;
        redirect_valid = 1'b0;
        n_acc = aq.size();
        tick();
        check_eq("t5_next_req", aq_at(n_acc), 32'h200);

        // ID stalled with memory always ready: credit stops at BUF_DEPTH.
        do_reset();
        lat = 1;
        stall_ifid = 1'b1;
        repeat (8) tick();
        check_eq("t6_accepts", 32'(aq.size()), 2);
        check_eq("t6_req_blocked", 32'(imem_req_valid), 0);
        check_eq("t6_ifid_empty", 32'(ifid_valid), 0);
        stall_ifid = 1'b0;
        repeat (4) tick();
        check_eq("t6_deliv0", dq_at(0), 32'h0);
        check_eq("t6_deliv1", dq_at(1), 32'h4);
        check_eq("t6_third_req", aq_at(2), 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
